// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the byte-stream handshake feeding the loader and the
//   instruction-memory write port driven by it.
//   Signals:
//     byte_valid  source has a byte
//     byte_data   byte payload
//     byte_ready  loader accepts a byte this cycle
//     we          instruction-memory write enable
//     waddr       byte address of the write
//     wdata       assembled 32-bit instruction word
//   Modports:
//     master  byte source / memory observer side
//     slave   loader side
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time instruction-memory loader. Collects a byte stream, packs
//   four bytes little-endian into a 32-bit word, writes each word to
//   consecutive word addresses and keeps the core in reset until the
//   full program has been written.
//   Ports:
//     clk         single clock, rising edge
//     reset       synchronous, active-high
//     start       one-cycle pulse that begins a load (IDLE/DONE/ERROR only)
//     num_words   words to load, sampled on an accepted start
//     bus         byte handshake + memory write port (slave modport)
//     core_reset  holds the core in reset (low only in DONE)
//     busy        load in progress
//     done        last load completed
//     error       last load aborted (bad length or stalled source)
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          TIMEOUT    = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_WIDTH:0] num_words,
    imem_loader_if.slave        bus,
    output logic                core_reset,
    output logic                busy,
    output logic                done,
    output logic                error
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam int TW = $clog2(TIMEOUT + 1);
    // Stall count at which the next stalled cycle aborts the load.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [2:0]          state_reg;
    logic [1:0]          byte_cnt_reg;
    logic [ADDR_WIDTH:0] word_cnt_reg;
    logic [ADDR_WIDTH:0] num_words_reg;
    logic [TW-1:0]       timeout_cnt_reg;
    logic [31:0]         waddr_reg;
    logic [31:0]         wdata_reg;

    logic                accept;
    logic [3:0]          lane_sel;
    logic [ADDR_WIDTH:0] word_cnt_next;

    // byte_ready is exactly "in RECV", so a handshake needs only valid here.
    assign accept        = (state_reg == S_RECV) && bus.byte_valid;
    assign word_cnt_next = word_cnt_reg + ONE_WORD;

    // One-hot lane select: byte k of the word lands in wdata[8k+7:8k].
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_sel[gi] = accept && (byte_cnt_reg == 2'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            byte_cnt_reg    <= 2'd0;
            word_cnt_reg    <= '0;
            num_words_reg   <= '0;
            timeout_cnt_reg <= '0;
            waddr_reg       <= BASE_ADDR;
            wdata_reg       <= 32'd0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        num_words_reg   <= num_words;
                        waddr_reg       <= BASE_ADDR;
                        byte_cnt_reg    <= 2'd0;
                        word_cnt_reg    <= '0;
                        timeout_cnt_reg <= '0;
                        if (num_words == '0)
                            state_reg <= S_DONE;
                        else if (num_words > MAX_WORDS)
                            state_reg <= S_ERROR;
                        else
                            state_reg <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (accept) begin
                        for (int i = 0; i < 4; i++) begin
                            if (lane_sel[i])
                                wdata_reg[8*i +: 8] <= bus.byte_data;
                        end
                        byte_cnt_reg    <= byte_cnt_reg + 2'd1;
                        timeout_cnt_reg <= '0;
                        if (byte_cnt_reg == 2'd3)
                            state_reg <= S_WRITE;
                    end else if (timeout_cnt_reg == TO_LAST) begin
                        // Partial word is simply abandoned; it is never written.
                        state_reg <= S_ERROR;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + TW'(1);
                    end
                end
                S_WRITE: begin
                    waddr_reg    <= waddr_reg + 32'd4;
                    word_cnt_reg <= word_cnt_next;
                    byte_cnt_reg <= 2'd0;
                    if (word_cnt_next == num_words_reg)
                        state_reg <= S_DONE;
                    else
                        state_reg <= S_RECV;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Control outputs are pure state decodes; address/data are registers.
    assign bus.byte_ready = (state_reg == S_RECV);
    assign bus.we         = (state_reg == S_WRITE);
    assign bus.waddr      = waddr_reg;
    assign bus.wdata      = wdata_reg;
    assign core_reset     = (state_reg != S_DONE);
    assign busy           = (state_reg == S_RECV) || (state_reg == S_WRITE);
    assign done           = (state_reg == S_DONE);
    assign error          = (state_reg == S_ERROR);
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    localparam int          AW   = 8;
    localparam int          TO   = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   num_words;
    logic          core_reset, busy, done, error;

    imem_loader_if bus();

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .bus(bus), .core_reset(core_reset), .busy(busy), .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: records every cycle where we is high.
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    int          done_rise_cyc = -1;
    logic        prev_done = 1'b0;
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            wq_addr.push_back(bus.waddr);
            wq_data.push_back(bus.wdata);
            wq_cyc.push_back(cyc);
        end
        if (done === 1'b1 && prev_done !== 1'b1) done_rise_cyc = cyc;
        prev_done = done;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] src[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        num_words = (AW+1)'(n);
        tick;
        start     = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid low one cycle before each byte, 2: random gaps 0..3
    task automatic stream(input int mode, input int nbytes);
        int   g, budget;
        logic rdy;
        for (int i = 0; i < nbytes; i++) begin
            g = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(3, 0));
            bus.byte_valid = 1'b0;
            repeat (g) tick;
            bus.byte_valid = 1'b1;
            bus.byte_data  = src[i];
            budget = 50;
            do begin
                rdy = bus.byte_ready;
                tick;
                budget--;
            end while (!rdy && budget > 0);
            if (!rdy) check("byte_accept_bound", 32'(rdy), 32'd1);
        end
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
    endtask

    task automatic wait_end;
        int budget;
        budget = 200;
        while (done !== 1'b1 && error !== 1'b1 && budget > 0) begin
            tick;
            budget--;
        end
        if (budget == 0) check("end_bound", 32'(done), 32'd1);
    endtask

    // Reference: word i is bytes 4i..4i+3 little-endian at BASE + 4i.
    task automatic check_load(input string tag, input int b, input int n);
        logic [31:0] exp_word;
        int          got;
        got = wq_addr.size() - b;
        check({tag, "_nwrites"}, 32'(got), 32'(n));
        for (int i = 0; i < n && i < got; i++) begin
            exp_word = 32'(src[4*i]) + (32'(src[4*i+1]) << 8)
                     + (32'(src[4*i+2]) << 16) + (32'(src[4*i+3]) << 24);
            check($sformatf("%s_addr%0d", tag, i), wq_addr[b+i], BASE + 32'(4*i));
            check($sformatf("%s_data%0d", tag, i), wq_data[b+i], exp_word);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd0);
        $display("[TB] load %s: %0d words, %0d writes seen", tag, n, got);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_we"}, 32'(bus.we), 32'd0);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_waddr"}, bus.waddr, BASE);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, n;
        reset = 1'b1; start = 1'b0; num_words = '0;
        bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
        repeat (3) tick;
        check_reset_vals("rst");
        check("rst_wdata", bus.wdata, 32'd0);
        reset = 1'b0;
        tick;

        // Directed two-word load, back-to-back bytes.
        src = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00};
        b = wq_addr.size();
        do_start(2);
        check("t1_ready_after_start", 32'(bus.byte_ready), 32'd1);
        check("t1_core_reset_busy", 32'(core_reset), 32'd1);
        stream(0, 8);
        wait_end;
        check_load("t1", b, 2);
        if (wq_addr.size() >= b + 2) begin
            check("t1_word0", wq_data[b], 32'h0000_0013);
            check("t1_word1", wq_data[b+1], 32'h0010_00B3);
            check("t1_spacing", 32'(wq_cyc[b+1] - wq_cyc[b]), 32'd5);
            check("t1_done_latency", 32'(done_rise_cyc - wq_cyc[b+1]), 32'd1);
        end

        // Same load, valid toggling; also a start pulse mid-load is ignored.
        b = wq_addr.size();
        do_start(2);
        start = 1'b1; num_words = '0;
        tick;
        start = 1'b0;
        check("t2_start_ignored", 32'(busy), 32'd1);
        stream(1, 8);
        wait_end;
        check_load("t2", b, 2);

        // Timeout: two bytes then silence.
        src = '{8'hAA, 8'hBB};
        b = wq_addr.size();
        do_start(1);
        stream(0, 2);
        repeat (TO - 1) tick;
        check("t3_no_error_yet", 32'(error), 32'd0);
        tick;
        check("t3_error", 32'(error), 32'd1);
        check("t3_core_reset", 32'(core_reset), 32'd1);
        check("t3_ready", 32'(bus.byte_ready), 32'd0);
        repeat (3) tick;
        check("t3_error_sticky", 32'(error), 32'd1);
        check("t3_no_write", 32'(wq_addr.size() - b), 32'd0);
        $display("[TB] load t3: timeout after 2 bytes, error=%0b", error);
        src = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        b = wq_addr.size();
        do_start(1);
        check("t3b_error_cleared", 32'(error), 32'd0);
        stream(0, 4);
        wait_end;
        check_load("t3b", b, 1);

        // Length boundaries.
        b = wq_addr.size();
        do_start(0);
        check("t4_zero_done", 32'(done), 32'd1);
        check("t4_zero_core_reset", 32'(core_reset), 32'd0);
        check("t4_zero_nowrite", 32'(wq_addr.size() - b), 32'd0);
        do_start((1 << AW) + 1);
        check("t4_over_error", 32'(error), 32'd1);
        check("t4_over_busy", 32'(busy), 32'd0);
        do_start(1 << AW);
        check("t4_max_busy", 32'(busy), 32'd1);
        check("t4_max_error", 32'(error), 32'd0);
        $display("[TB] load t4: length 0 / 2**AW+1 / 2**AW");

        // Reset mid-word, with start coincident.
        reset = 1'b1; start = 1'b1; num_words = (AW+1)'(1);
        tick;
        reset = 1'b0; start = 1'b0;
        check_reset_vals("t5a");
        src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        b = wq_addr.size();
        do_start(2);
        stream(0, 6);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_reset_vals("t5b");
        tick;
        check("t5_one_write", 32'(wq_addr.size() - b), 32'd1);
        $display("[TB] load t5: reset after 6 bytes");
        src.delete();
        for (int i = 0; i < 8; i++) src.push_back(8'($urandom));
        b = wq_addr.size();
        do_start(2);
        stream(0, 8);
        wait_end;
        check_load("t5c", b, 2);

        // Randomized loads.
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(5, 1));
            src.delete();
            for (int i = 0; i < 4*n; i++) src.push_back(8'($urandom));
            b = wq_addr.size();
            do_start(n);
            stream(2, 4*n);
            wait_end;
            check_load($sformatf("rnd%0d", r), b, n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
